// File: rtl/arm_pipelined_execute_control.sv
// arm_pipelined_execute_control: Decode/Execute control register, NZCV flags and condition gating; optional stall hold under ARM_PIPELINED_EXEC_STALL_EN
module arm_pipelined_execute_control (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_Flush_Execute,
    input  logic       i_Stall_Execute,
    input  logic [3:0] i_Cond_Decode,
    input  logic       i_PC_Src_Decode,
    input  logic       i_Reg_Write_Decode,
    input  logic       i_Mem_Write_Decode,
    input  logic       i_Mem_To_Reg_Decode,
    input  logic       i_ALU_Src_Decode,
    input  logic       i_No_Write_Decode,
    input  logic [1:0] i_ALU_Control_Decode,
    input  logic [1:0] i_Flag_Write_Decode,
    input  logic [3:0] i_ALU_Flags,
    output logic       o_PC_Src_Execute,
    output logic       o_Reg_Write_Execute,
    output logic       o_Mem_Write_Execute,
    output logic       o_Mem_To_Reg_Execute,
    output logic       o_ALU_Src_Execute,
    output logic [1:0] o_ALU_Control_Execute,
    output logic       o_Cond_Ex_Execute,
    output logic [3:0] o_Flags
);
    typedef struct packed {
        logic [3:0] cond;
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       no_write;
        logic [1:0] alu_control;
        logic [1:0] flag_write;
    } ex_ctrl_t;
    ex_ctrl_t   ex_q, ex_d;
    logic [3:0] flags_q;
    logic       n, z, c, v, cond_ex, hold;
`ifdef ARM_PIPELINED_EXEC_STALL_EN
    assign hold = i_Stall_Execute & ~i_Flush_Execute;
`else
    logic unused_stall;
    assign unused_stall = i_Stall_Execute;
    assign hold = 1'b0;
`endif
    assign ex_d = i_Flush_Execute ? '0 : {i_Cond_Decode, i_PC_Src_Decode, i_Reg_Write_Decode,
                                          i_Mem_Write_Decode, i_Mem_To_Reg_Decode, i_ALU_Src_Decode,
                                          i_No_Write_Decode, i_ALU_Control_Decode, i_Flag_Write_Decode};
    assign {n, z, c, v} = flags_q;
    // Condition field evaluated against the flags held before this instruction's own update
    always_comb begin
        cond_ex = 1'b0;
        case (ex_q.cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = n == v;
            4'b1011: cond_ex = n != v;
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
    // Execute control register: flush injects an all-zero bubble, stall (when enabled) holds
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) ex_q <= '0;
        else if (!hold) ex_q <= ex_d;
    end
    // NZ and CV pairs update independently, only for an executing, non-held instruction
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) flags_q <= '0;
        else if (!hold) begin
            if (ex_q.flag_write[1] & cond_ex) flags_q[3:2] <= i_ALU_Flags[3:2];
            if (ex_q.flag_write[0] & cond_ex) flags_q[1:0] <= i_ALU_Flags[1:0];
        end
    end
    assign o_PC_Src_Execute      = ex_q.pc_src & cond_ex;
    assign o_Reg_Write_Execute   = ex_q.reg_write & cond_ex & ~ex_q.no_write;
    assign o_Mem_Write_Execute   = ex_q.mem_write & cond_ex;
    assign o_Mem_To_Reg_Execute  = ex_q.mem_to_reg;
    assign o_ALU_Src_Execute     = ex_q.alu_src;
    assign o_ALU_Control_Execute = ex_q.alu_control;
    assign o_Cond_Ex_Execute     = cond_ex;
    assign o_Flags               = flags_q;
endmodule

// File: tb/tb_arm_pipelined_execute_control.sv
// tb_arm_pipelined_execute_control: scoreboard bench for arm_pipelined_execute_control (stall cases follow ARM_PIPELINED_EXEC_STALL_EN)
module tb_arm_pipelined_execute_control;
    logic       clk = 1'b0, rst = 1'b1, flush = 1'b0, stall = 1'b0;
    logic [3:0] cond = '0, alu_flags = '0;
    logic       pc_src = 1'b0, reg_write = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0, alu_src = 1'b0, no_write = 1'b0;
    logic [1:0] alu_control = '0, flag_write = '0;
    logic       o_pc_src, o_reg_write, o_mem_write, o_mem_to_reg, o_alu_src, o_cond_ex;
    logic [1:0] o_alu_control;
    logic [3:0] o_flags;
    logic [11:0] act;
    int checks = 0, errors = 0, cyc = 0;
    typedef struct {
        string       name;
        int          cyc;
        logic [11:0] exp;
    } exp_t;
    exp_t sb[$];

    arm_pipelined_execute_control dut (
        .i_CLK(clk), .i_RST(rst), .i_Flush_Execute(flush), .i_Stall_Execute(stall),
        .i_Cond_Decode(cond), .i_PC_Src_Decode(pc_src), .i_Reg_Write_Decode(reg_write),
        .i_Mem_Write_Decode(mem_write), .i_Mem_To_Reg_Decode(mem_to_reg), .i_ALU_Src_Decode(alu_src),
        .i_No_Write_Decode(no_write), .i_ALU_Control_Decode(alu_control), .i_Flag_Write_Decode(flag_write),
        .i_ALU_Flags(alu_flags), .o_PC_Src_Execute(o_pc_src), .o_Reg_Write_Execute(o_reg_write),
        .o_Mem_Write_Execute(o_mem_write), .o_Mem_To_Reg_Execute(o_mem_to_reg), .o_ALU_Src_Execute(o_alu_src),
        .o_ALU_Control_Execute(o_alu_control), .o_Cond_Ex_Execute(o_cond_ex), .o_Flags(o_flags)
    );

    assign act = {o_pc_src, o_reg_write, o_mem_write, o_mem_to_reg, o_alu_src, o_alu_control, o_cond_ex, o_flags};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got pc/rw/mw/mtr/asrc/aluc/cx/flags=%b expected %b", name, got, exp);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the oldest due expectation
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, act, e.exp);
        end
    end

    // Drives one Decode-stage instruction plus the ALU flags for the instruction currently in Execute
    task automatic step(input string name, input logic [3:0] c, input logic [5:0] ctl, input logic [1:0] aluc,
                        input logic [1:0] fw, input logic [3:0] af, input logic fl, input logic st,
                        input logic [11:0] exp);
        exp_t e;
        cond = c;
        {pc_src, reg_write, mem_write, mem_to_reg, alu_src, no_write} = ctl;
        alu_control = aluc;
        flag_write = fw;
        alu_flags = af;
        flush = fl;
        stall = st;
        e.name = name;
        e.cyc = cyc + 1;
        e.exp = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_init", act, 12'b0);
        rst = 1'b0;
        //    name     cond     pc rw mw mtr asrc nw  aluc   fw     aluf     fl st  exp {pc,rw,mw,mtr,asrc,aluc,cx,flags}
        step("v1_al",  4'b1110, 6'b010000, 2'b00, 2'b11, 4'b0000, 0, 0, 12'b0_1_0_0_0_00_1_0000);
        @(negedge clk);
        #1;
        rst = 1'b1;
        alu_flags = 4'b1111;
        {cond, pc_src, reg_write, mem_write, mem_to_reg, alu_src, no_write, alu_control, flag_write} = '0;
        #1;
        check("reset_async", act, 12'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("cmp",        4'b1110, 6'b010011, 2'b01, 2'b11, 4'b0000, 0, 0, 12'b0_0_0_0_1_01_1_0000);
        step("beq",        4'b0000, 6'b100000, 2'b00, 2'b00, 4'b0100, 0, 0, 12'b1_0_0_0_0_00_1_0100);
        step("clr_flags",  4'b1110, 6'b000000, 2'b00, 2'b11, 4'b0000, 0, 0, 12'b0_0_0_0_0_00_1_0100);
        step("eq_fail",    4'b0000, 6'b011000, 2'b00, 2'b11, 4'b0000, 0, 0, 12'b0_0_0_0_0_00_0_0000);
        step("mtr_al",     4'b1110, 6'b000100, 2'b00, 2'b11, 4'b1111, 0, 0, 12'b0_0_0_1_0_00_1_0000);
        step("set_all",    4'b1110, 6'b000000, 2'b00, 2'b10, 4'b1111, 0, 0, 12'b0_0_0_0_0_00_1_1111);
        step("hi_partial", 4'b1000, 6'b100000, 2'b00, 2'b00, 4'b0000, 0, 0, 12'b1_0_0_0_0_00_1_0011);
        step("ge_fail",    4'b1010, 6'b010000, 2'b00, 2'b00, 4'b1010, 0, 0, 12'b0_0_0_0_0_00_0_0011);
        step("lt_pass",    4'b1011, 6'b010000, 2'b00, 2'b01, 4'b1010, 0, 0, 12'b0_1_0_0_0_00_1_0011);
        step("nv_cv_upd",  4'b1111, 6'b100000, 2'b00, 2'b00, 4'b1110, 0, 0, 12'b0_0_0_0_0_00_0_0010);
        step("flush",      4'b1110, 6'b110000, 2'b00, 2'b11, 4'b0000, 1, 0, 12'b0_0_0_0_0_00_0_0010);
        step("flush_stall",4'b1110, 6'b111000, 2'b00, 2'b11, 4'b0000, 1, 1, 12'b0_0_0_0_0_00_0_0010);
        step("load_fw11",  4'b1110, 6'b010000, 2'b10, 2'b11, 4'b0000, 0, 0, 12'b0_1_0_0_0_10_1_0010);
`ifdef ARM_PIPELINED_EXEC_STALL_EN
        step("stall1",     4'b0000, 6'b100000, 2'b11, 2'b00, 4'b1000, 0, 1, 12'b0_1_0_0_0_10_1_0010);
        step("stall2",     4'b0000, 6'b100000, 2'b11, 2'b00, 4'b0100, 0, 1, 12'b0_1_0_0_0_10_1_0010);
        step("after_stall",4'b1110, 6'b000000, 2'b00, 2'b00, 4'b0001, 0, 0, 12'b0_0_0_0_0_00_1_0001);
`else
        step("stall1",     4'b0000, 6'b100000, 2'b11, 2'b00, 4'b1000, 0, 1, 12'b0_0_0_0_0_11_0_1000);
        step("stall2",     4'b0000, 6'b100000, 2'b11, 2'b00, 4'b0100, 0, 1, 12'b0_0_0_0_0_11_0_1000);
        step("after_stall",4'b1110, 6'b000000, 2'b00, 2'b00, 4'b0001, 0, 0, 12'b0_0_0_0_0_00_1_1000);
`endif
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
